// File: rtl/cpu_tb_pkg.sv
// Shared FSM state encoding and fail-code constants for the CPU test controller.
// Pure declarations: no latency, no flow control.
package cpu_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] FC_PASS    = 2'd0;
    localparam logic [1:0] FC_BAD_SIG = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_HALT    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: count visible one cycle after enable; holds at all-ones, no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_test_ctrl.sv
// Test harness controller: resets the CPU, runs it, and grades pass/bad-sig/halt/timeout.
// Latency: every output registered, results visible the cycle after the terminating event.
module cpu_test_ctrl
    import cpu_tb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 5,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 4,
    parameter int                TIMEOUT     = 10000,
    parameter int                HALT_CYCLES = 8,
    parameter int                SIG_REG     = 31,
    parameter logic [DATA_W-1:0] PASS_VAL    = DATA_W'(32'h0000_600D)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              cpu_rst,
    input  logic [DATA_W-1:0] pc,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int RC_W    = $clog2(RST_CYCLES + 1);
    localparam int STALL_W = $clog2(HALT_CYCLES + 1);

    state_t              r_state;
    logic [RC_W-1:0]     r_rst_cnt;
    logic [DATA_W-1:0]   r_pc_prev;

    logic                w_start_acc;
    logic                w_clr;
    logic                w_run;
    logic                w_wr_vld;
    logic                w_pc_same;
    logic                w_sig_hit;
    logic                w_halt;
    logic                w_timeout;
    logic [STALL_W-1:0]  w_stall_cnt;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_clr       = rst || w_start_acc;
    assign w_run       = (r_state == ST_RUN);
    // Address 0 is hardwired zero in the CPU, so its writes never count or terminate.
    assign w_wr_vld    = rf_we && (rf_waddr != '0);
    assign w_pc_same   = (pc == r_pc_prev);
    assign w_sig_hit   = w_run && w_wr_vld && (rf_waddr == ADDR_W'(SIG_REG));
    assign w_halt      = w_run && (w_stall_cnt == STALL_W'(HALT_CYCLES - 1));
    assign w_timeout   = w_run && (cycle_cnt == CNT_W'(TIMEOUT - 1));

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_clk (clk),
        .i_clr (w_clr),
        .i_en  (w_run),
        .o_cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .i_clk (clk),
        .i_clr (w_clr),
        .i_en  (w_run && w_wr_vld),
        .o_cnt (wr_cnt)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .i_clk (clk),
        .i_clr (w_clr || (w_run && !w_pc_same)),
        .i_en  (w_run && w_pc_same),
        .o_cnt (w_stall_cnt)
    );

    always_ff @(posedge clk) begin
        r_pc_prev <= pc;
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rst_cnt <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_PASS;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_RESET;
                        r_rst_cnt <= '0;
                        cpu_rst   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_code <= FC_PASS;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state <= ST_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Signature beats halt beats timeout when they coincide.
                    if (w_sig_hit || w_halt || w_timeout) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    if (w_sig_hit) begin
                        pass      <= (rf_wdata == PASS_VAL);
                        fail_code <= (rf_wdata == PASS_VAL) ? FC_PASS : FC_BAD_SIG;
                    end else if (w_halt) begin
                        fail_code <= FC_HALT;
                    end else if (w_timeout) begin
                        fail_code <= FC_TIMEOUT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Scoreboard bench for cpu_test_ctrl: per-run stimulus plans graded by a cycle-walk reference model.
module tb_cpu_test_ctrl;

    localparam int TMO   = 50;
    localparam int HALT  = 8;
    localparam int RSTC  = 4;

    logic        clk = 1'b0;
    logic        rst, start, rf_we;
    logic [31:0] pc, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        cpu_rst, busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_cnt, wr_cnt;

    always #5 clk = ~clk;

    cpu_test_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .cpu_rst(cpu_rst), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
    );

    typedef struct {
        logic       pass;
        logic [1:0] code;
        int         cyc;
        int         wr;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] p_pc [TMO];
    logic        p_we [TMO];
    logic [4:0]  p_wa [TMO];
    logic [31:0] p_wd [TMO];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: walk the planned RUN cycles, applying the grading rules in priority order.
    task automatic model(output exp_t e);
        int          wr = 0;
        int          streak = 0;
        bit          fin = 0;
        logic [31:0] prev = p_pc[0];
        e.pass = 0; e.code = 2'd2; e.cyc = TMO; e.wr = 0;
        for (int k = 0; k < TMO && !fin; k++) begin
            if (p_we[k] && p_wa[k] != 5'd0) wr++;
            if (p_we[k] && p_wa[k] == 5'd31) begin
                e.pass = (p_wd[k] == 32'h0000_600D);
                e.code = e.pass ? 2'd0 : 2'd1;
                fin = 1;
            end else if (streak >= HALT - 1) begin
                e.code = 2'd3;
                fin = 1;
            end else if (k == TMO - 1) begin
                e.code = 2'd2;
                fin = 1;
            end
            if (fin) begin
                e.cyc = k + 1;
                e.wr  = wr;
            end
            streak = (p_pc[k] == prev) ? streak + 1 : 0;
            prev   = p_pc[k];
        end
    endtask

    task automatic plan_clear();
        for (int k = 0; k < TMO; k++) begin
            p_pc[k] = 32'h100 + 32'(4 * k);
            p_we[k] = 0; p_wa[k] = 0; p_wd[k] = 0;
        end
    endtask

    task automatic plan_random();
        logic [31:0] cur = $urandom;
        int hold_p = $urandom_range(1, 6);
        for (int k = 0; k < TMO; k++) begin
            if ($urandom_range(0, 9) >= hold_p) cur = cur + 32'd4;
            p_pc[k] = cur;
            p_we[k] = ($urandom_range(0, 9) < 3);
            p_wa[k] = 5'($urandom_range(0, 31));
            if (p_wa[k] == 5'd31 && $urandom_range(0, 5) != 0) p_wa[k] = 5'd30;
            p_wd[k] = $urandom_range(0, 1) ? 32'h0000_600D : $urandom;
        end
    endtask

    task automatic run_plan(input int abort_at, input bit rnd_start);
        exp_t e;
        int   rlen;
        bit   seen;
        model(e);
        if (abort_at < 0) q.push_back(e);
        start = 1; pc = p_pc[0]; rf_we = 0;
        @(posedge clk); #1;
        start = 0;
        rlen = 0;
        while (cpu_rst && rlen < 20) begin
            rlen++;
            @(posedge clk); #1;
        end
        chk("rst_len", rlen, RSTC);
        seen = 0;
        for (int k = 0; k < TMO && !seen; k++) begin
            pc = p_pc[k]; rf_we = p_we[k]; rf_waddr = p_wa[k]; rf_wdata = p_wd[k];
            start = rnd_start && ($urandom_range(0, 7) == 0);
            rst = (k == abort_at);
            @(posedge clk); #1;
            if (k == abort_at) begin
                rst = 0; rf_we = 0; start = 0;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_cpu_rst", cpu_rst, 1);
                chk("abort_cycle_cnt", cycle_cnt, 0);
                chk("abort_wr_cnt", wr_cnt, 0);
                @(posedge clk); #1;
                return;
            end
            seen = done;
        end
        rf_we = 0; start = 0;
        chk("done_seen", seen, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", done, 1);
        chk("cpu_rst_in_done", cpu_rst, 0);
    endtask

    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                m_e = q.pop_front();
                chk("pass", pass, m_e.pass);
                chk("fail_code", fail_code, m_e.code);
                chk("cycle_cnt", cycle_cnt, m_e.cyc);
                chk("wr_cnt", wr_cnt, m_e.wr);
                chk("busy_in_done", busy, 0);
            end
        end
        done_q <= done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; pc = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_cpu_rst", cpu_rst, 1);

        // Pass at RUN cycle 20 with assorted writes before it.
        plan_clear();
        for (int k = 0; k < 20; k += 3) begin
            p_we[k] = 1; p_wa[k] = 5'(1 + k % 30); p_wd[k] = $urandom;
        end
        p_we[20] = 1; p_wa[20] = 5'd31; p_wd[20] = 32'h0000_600D;
        run_plan(-1, 0);

        // Bad signature, including r0 writes that must not count.
        plan_clear();
        for (int k = 0; k < 15; k += 2) begin
            p_we[k] = 1; p_wa[k] = (k % 4 == 0) ? 5'd0 : 5'd9; p_wd[k] = $urandom;
        end
        p_we[15] = 1; p_wa[15] = 5'd31; p_wd[15] = 32'h0000_0BAD;
        run_plan(-1, 0);

        // Halt at a fixed PC.
        plan_clear();
        for (int k = 0; k < TMO; k++) begin
            p_pc[k] = 32'h40;
            if (k % 3 == 1) begin p_we[k] = 1; p_wa[k] = 5'd5; p_wd[k] = 32'(k); end
        end
        run_plan(-1, 0);

        // Timeout with r0 writes carrying the pass value.
        plan_clear();
        for (int k = 0; k < TMO; k++) begin
            p_we[k] = 1; p_wa[k] = (k % 5 == 0) ? 5'd7 : 5'd0; p_wd[k] = 32'h0000_600D;
        end
        run_plan(-1, 0);

        // Signature and timeout in the same cycle.
        plan_clear();
        p_we[TMO-1] = 1; p_wa[TMO-1] = 5'd31; p_wd[TMO-1] = 32'h0000_600D;
        run_plan(-1, 0);

        // Signature and halt in the same cycle.
        plan_clear();
        for (int k = 0; k < TMO; k++) p_pc[k] = 32'h80;
        p_we[HALT-1] = 1; p_wa[HALT-1] = 5'd31; p_wd[HALT-1] = 32'h1234;
        run_plan(-1, 0);

        // Harness reset in the middle of a run.
        plan_clear();
        for (int k = 0; k < TMO; k++) begin p_we[k] = 1; p_wa[k] = 5'd3; end
        run_plan(10, 0);

        for (int r = 0; r < 16; r++) begin
            plan_random();
            run_plan(-1, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
